// File: rtl/store_buffer_if.sv
// EX->TL store-buffer port bundle: pipeline slot inputs, load-forward results and the cache drain handshake.
interface store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_store;
    logic              in_load;
    logic              in_isbyte;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic              stall;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              dc_req_valid;
    logic              dc_req_ready;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [DATA_W-1:0] dc_req_data;
    logic              dc_req_isbyte;
    logic              empty;

    modport master (
        output in_valid, in_store, in_load, in_isbyte, in_addr, in_wdata, dc_req_ready,
        input  stall, fwd_hit, fwd_data, dc_req_valid, dc_req_addr, dc_req_data, dc_req_isbyte, empty
    );
    modport slave (
        input  in_valid, in_store, in_load, in_isbyte, in_addr, in_wdata, dc_req_ready,
        output stall, fwd_hit, fwd_data, dc_req_valid, dc_req_addr, dc_req_data, dc_req_isbyte, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Committed-store FIFO between EX and the data-cache write port, with load lookup against queued stores.
// Define STORE_BUF_FWD_EN to forward matching store data to loads instead of stalling on every overlap.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic          clk,
    input logic          rst,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] e_addr;
    logic [DEPTH-1:0][DATA_W-1:0] e_data;
    logic [DEPTH-1:0]             e_vld;
    logic [DEPTH-1:0]             e_byte;
    logic [PW-1:0]                head, tail;
    logic [PW:0]                  count;
    logic                         full, emp, enq, deq, lookup, conflict, hit;
    logic [DATA_W-1:0]            data;
    logic [DEPTH-1:0]             mvec;

    assign full   = (count == (PW+1)'(DEPTH));
    assign emp    = (count == '0);
    assign enq    = sb.in_valid & sb.in_store & !full;
    assign deq    = !emp & sb.dc_req_ready;
    assign lookup = sb.in_valid & sb.in_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            e_vld <= '0;
        end else begin
            if (enq) begin
                e_addr[tail] <= sb.in_addr;
                e_data[tail] <= sb.in_wdata;
                e_byte[tail] <= sb.in_isbyte;
                e_vld[tail]  <= 1'b1;
                tail         <= tail + PW'(1);
            end
            // enq and deq never target the same slot: that needs count 0 or DEPTH
            if (deq) begin
                e_vld[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign mvec[i] = e_vld[i] & (e_addr[i][ADDR_W-1:2] == sb.in_addr[ADDR_W-1:2]);
    end

`ifdef STORE_BUF_FWD_EN
    logic [PW-1:0]     yi;
    logic              found;
    logic [DATA_W-1:0] lane;

    always_comb begin
        found    = 1'b0;
        yi       = '0;
        // walk oldest to youngest so the last match is the youngest store
        for (int k = 0; k < DEPTH; k++) begin
            if (mvec[head + PW'(k)]) begin
                found = 1'b1;
                yi    = head + PW'(k);
            end
        end
        lane     = e_data[yi] >> {sb.in_addr[1:0], 3'b000};
        hit      = 1'b0;
        data     = '0;
        conflict = 1'b0;
        if (lookup && found) begin
            if (!e_byte[yi]) begin
                hit  = 1'b1;
                data = sb.in_isbyte ? {{(DATA_W-8){1'b0}}, lane[7:0]} : e_data[yi];
            end else if (sb.in_isbyte && e_addr[yi][1:0] == sb.in_addr[1:0]) begin
                hit  = 1'b1;
                data = {{(DATA_W-8){1'b0}}, e_data[yi][7:0]};
            end else begin
                conflict = 1'b1;
            end
        end
    end
`else
    assign conflict = lookup & (|mvec);
    assign hit      = 1'b0;
    assign data     = '0;
`endif

    assign sb.stall         = sb.in_valid & ((sb.in_store & full) | (sb.in_load & conflict));
    assign sb.fwd_hit       = hit;
    assign sb.fwd_data      = data;
    assign sb.dc_req_valid  = !emp;
    assign sb.dc_req_addr   = e_addr[head];
    assign sb.dc_req_data   = e_data[head];
    assign sb.dc_req_isbyte = e_byte[head];
    assign sb.empty         = emp;
endmodule

// File: tb/tb_store_buffer.sv
// Directed and random checks of store_buffer against a queue-based model of the store FIFO.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    store_buffer_if #(.ADDR_W(32), .DATA_W(32)) sb ();
    store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .sb(sb));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        isbyte;
    } ent_t;

    ent_t        q[$];
    logic [31:0] drained[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected lookup result from the queued stores (index 0 = oldest)
    function automatic void model(input logic v, st, ld, ib, input logic [31:0] a,
                                  output logic o_stall, output logic o_hit, output logic [31:0] o_data);
        int   y = -1;
        logic conf = 1'b0;
        o_hit  = 1'b0;
        o_data = 32'h0;
        if (v && ld)
            for (int i = 0; i < q.size(); i++)
                if (q[i].addr[31:2] == a[31:2]) y = i;
        if (y >= 0) begin
`ifdef STORE_BUF_FWD_EN
            if (!q[y].isbyte) begin
                o_hit  = 1'b1;
                o_data = ib ? ((q[y].data >> (8 * a[1:0])) & 32'hFF) : q[y].data;
            end else if (ib && q[y].addr[1:0] == a[1:0]) begin
                o_hit  = 1'b1;
                o_data = q[y].data & 32'hFF;
            end else begin
                conf = 1'b1;
            end
`else
            conf = 1'b1;
`endif
        end
        o_stall = v && ((st && q.size() == DEPTH) || (ld && conf));
    endfunction

    task automatic step(input logic v, st, ld, ib, input logic [31:0] a, d, input logic rdy);
        logic        ex_stall, ex_hit, enq, deq;
        logic [31:0] ex_data;
        sb.in_valid = v; sb.in_store = st; sb.in_load = ld; sb.in_isbyte = ib;
        sb.in_addr = a; sb.in_wdata = d; sb.dc_req_ready = rdy;
        #2;
        model(v, st, ld, ib, a, ex_stall, ex_hit, ex_data);
        chk("empty", 32'(sb.empty), 32'(q.size() == 0));
        chk("dc_req_valid", 32'(sb.dc_req_valid), 32'(q.size() != 0));
        chk("stall", 32'(sb.stall), 32'(ex_stall));
        chk("fwd_hit", 32'(sb.fwd_hit), 32'(ex_hit));
        chk("fwd_data", sb.fwd_data, ex_data);
        if (q.size() != 0) begin
            chk("dc_req_addr", sb.dc_req_addr, q[0].addr);
            chk("dc_req_data", sb.dc_req_data, q[0].data);
            chk("dc_req_isbyte", 32'(sb.dc_req_isbyte), 32'(q[0].isbyte));
        end
        if (sb.dc_req_valid && rdy) drained.push_back(sb.dc_req_addr);
        enq = v && st && q.size() < DEPTH;
        deq = q.size() != 0 && rdy;
        @(posedge clk);
        if (deq) void'(q.pop_front());
        if (enq) q.push_back('{a, d, ib});
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        sb.in_valid = 1'b0; sb.in_store = 1'b0; sb.in_load = 1'b0; sb.in_isbyte = 1'b0;
        sb.in_addr = '0; sb.in_wdata = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    initial begin
        sb.dc_req_ready = 1'b0;
        rst = 1'b1;
        do_reset();

        // 1: idle after reset
        repeat (10) idle(1'b0);

        // 2: fill, stall on full, in-order drain
        drained.delete();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 32'h100 + 32'(i * 4), 32'hD000 + 32'(i), 0);
        chk("t2_not_empty", 32'(sb.empty), 32'h0);
        step(1, 1, 0, 0, 32'h110, 32'hD004, 0);
        step(1, 1, 0, 0, 32'h110, 32'hD004, 1);
        step(1, 1, 0, 0, 32'h110, 32'hD004, 1);
        repeat (4) idle(1'b1);
        chk("t2_drain_count", 32'(drained.size()), 32'd5);
        if (drained.size() == 5) begin
            chk("t2_drain0", drained[0], 32'h100);
            chk("t2_drain1", drained[1], 32'h104);
            chk("t2_drain2", drained[2], 32'h108);
            chk("t2_drain3", drained[3], 32'h10C);
            chk("t2_drain4", drained[4], 32'h110);
        end

        // 3: byte load from a queued word store
        do_reset();
        step(1, 1, 0, 0, 32'h200, 32'hAABBCCDD, 0);
        step(1, 0, 1, 1, 32'h201, 32'h0, 0);
`ifdef STORE_BUF_FWD_EN
        chk("t3_fwd_data", sb.fwd_data, 32'h000000CC);
        chk("t3_stall", 32'(sb.stall), 32'h0);
`else
        chk("t3_stall", 32'(sb.stall), 32'h1);
`endif

        // 4: word load over a queued byte store stalls until it drains
        do_reset();
        step(1, 1, 0, 1, 32'h300, 32'h5A, 0);
        step(1, 0, 1, 0, 32'h300, 32'h0, 0);
        chk("t4_stall", 32'(sb.stall), 32'h1);
        step(1, 0, 1, 0, 32'h300, 32'h0, 1);
        step(1, 0, 1, 0, 32'h300, 32'h0, 1);
        chk("t4_after_hit", 32'(sb.fwd_hit), 32'h0);

        // 5: youngest of two matching stores wins
        do_reset();
        step(1, 1, 0, 0, 32'h400, 32'h1111, 0);
        step(1, 1, 0, 0, 32'h400, 32'h2222, 0);
        step(1, 0, 1, 0, 32'h400, 32'h0, 0);
`ifdef STORE_BUF_FWD_EN
        chk("t5_youngest", sb.fwd_data, 32'h2222);
`else
        chk("t5_stall", 32'(sb.stall), 32'h1);
`endif
        repeat (3) step(1, 0, 1, 0, 32'h400, 32'h0, 1);

        // 6: store against full buffer while draining, then reset mid-drain
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, i[0], 32'h600 + 32'(i * 4), 32'hE0 + 32'(i), 0);
        step(1, 1, 0, 0, 32'h610, 32'hE4, 1);
        idle(1'b0);
        idle(1'b1);
        sb.dc_req_ready = 1'b1;
        do_reset();
        idle(1'b1);
        chk("t6_reset_empty", 32'(sb.empty), 32'h1);

        // random traffic over a few words, with ready throttled in phases
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic        v, st, ld, ib, rdy;
            logic [31:0] a;
            int          kind;
            v    = ($urandom_range(0, 9) != 0);
            kind = $urandom_range(0, 2);
            st   = (kind == 0);
            ld   = (kind == 1);
            ib   = $urandom_range(0, 1) != 0;
            a    = 32'h500 + 32'($urandom_range(0, 3) * 4);
            if (ib) a[1:0] = 2'($urandom_range(0, 3));
            rdy  = ((i % 40) < 15) ? 1'b0 : ($urandom_range(0, 2) != 0);
            step(v, st, ld, ib, a, $urandom, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
